// File: rtl/rx_lvds.sv
// Serial LVDS frame receiver: start bit (0), CH_NUM*8 data bits LSB first, stop bit (1).
// Transmitter shares the clock, so every bit is sampled exactly once.
`ifndef CH_NUM
`define CH_NUM 1
`endif

module rx_lvds #(
  parameter int unsigned CH_NUM = `CH_NUM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [CH_NUM*8-1:0]   data_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int unsigned N    = CH_NUM * 8;
  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StData, StStop, StHunt} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    shift_q, shift_d;
  logic [N-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            s1_q, s2_q;

  // Two-flop synchroniser; resets to the idle line level so release is not a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= rx;
      s2_q <= s1_q;
    end
  end

  // Frame FSM next-state, shift register and output pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!s2_q) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end
      StData: begin
        // Right shift: after N shifts the first bit received sits at bit 0.
        shift_d = {s2_q, shift_q[N-1:1]};
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (s2_q) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = StIdle;
        end else begin
          err_d   = 1'b1;
          state_d = StHunt;
        end
      end
      StHunt: begin
        // Wait for the line to go high so a stuck-low line is not re-read as starts.
        if (s2_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign rx_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_rx_lvds.sv
// Testbench for rx_lvds: two instances (CH_NUM=1 and CH_NUM=2) driven by bit streams.
// Expected outputs come from a frame-level parse of each stream.
module tb_rx_lvds;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx1 = 1'b1;
  logic        rx2 = 1'b1;
  logic [7:0]  d1;
  logic        v1, e1, b1;
  logic [15:0] d2;
  logic        v2, e2, b2;

  always #5 clk = ~clk;

  rx_lvds #(.CH_NUM(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1),
    .data_out(d1), .data_valid(v1), .frame_err(e1), .rx_busy(b1)
  );

  rx_lvds #(.CH_NUM(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx2),
    .data_out(d2), .data_valid(v2), .frame_err(e2), .rx_busy(b2)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  logic        stim[$];
  logic        exp_v[$];
  logic        exp_e[$];
  logic        exp_b[$];
  logic [15:0] exp_d[$];
  int          vcyc[$];
  int          ecyc[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rxb(input int i);
    if (i < 0 || i >= stim.size()) return 1'b1;
    return stim[i];
  endfunction

  // Parse the stream into frames: find a 0 while idle, read n bits, judge the stop bit.
  // Sample k of the stream reaches the FSM in cycle k+2, so events land at start+4+n.
  function automatic void build_model(input int n);
    int L;
    int q;
    int c;
    int h;
    int ev;
    logic [15:0] w;
    L = stim.size();
    exp_v.delete(); exp_e.delete(); exp_b.delete(); exp_d.delete();
    for (int t = 0; t < L; t++) begin
      exp_v.push_back(1'b0); exp_e.push_back(1'b0);
      exp_b.push_back(1'b0); exp_d.push_back(16'h0);
    end
    q = 0;
    while (1) begin
      c = q;
      while (c < L && rxb(c)) c++;
      if (c >= L) break;
      w = '0;
      for (int k = 0; k < n; k++) w[k] = rxb(c + 1 + k);
      for (int t = c + 3; t <= c + 3 + n; t++) if (t < L) exp_b[t] = 1'b1;
      ev = c + 4 + n;
      if (rxb(c + 1 + n)) begin
        if (ev < L) exp_v[ev] = 1'b1;
        for (int t = ev; t < L; t++) exp_d[t] = w;
        q = c + 2 + n;
      end else begin
        if (ev < L) exp_e[ev] = 1'b1;
        h = c + 2 + n;
        while (h < L && !rxb(h)) h++;
        for (int t = ev; t <= h + 2; t++) if (t < L) exp_b[t] = 1'b1;
        q = h + 1;
      end
    end
  endfunction

  task automatic push_idle(input int k);
    for (int i = 0; i < k; i++) stim.push_back(1'b1);
  endtask

  task automatic push_frame(input int n, input logic [15:0] w, input logic stop);
    stim.push_back(1'b0);
    for (int k = 0; k < n; k++) stim.push_back(w[k]);
    stim.push_back(stop);
  endtask

  task automatic add_rand_frames(input int n, input int cnt);
    logic [15:0] w;
    logic        stop;
    for (int f = 0; f < cnt; f++) begin
      push_idle($urandom_range(0, 2));
      w    = 16'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      push_frame(n, w, stop);
      if (!stop) for (int z = 0; z < int'($urandom_range(0, 5)); z++) stim.push_back(1'b0);
    end
    push_idle(n + 6);
  endtask

  // Assert reset at a falling edge, verify outputs clear immediately, release next falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    rx1 = 1'b1;
    rx2 = 1'b1;
    #1;
    check({tag, ".rst.d1"}, {8'h00, d1}, 16'h0);
    check({tag, ".rst.v1e1b1"}, {13'h0, v1, e1, b1}, 16'h0);
    check({tag, ".rst.d2"}, d2, 16'h0);
    check({tag, ".rst.v2e2b2"}, {13'h0, v2, e2, b2}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Play stim on one instance, one bit per cycle, comparing every cycle against the model.
  task automatic run_seg(input int sel, input string tag);
    int n;
    logic [15:0] od;
    logic        ov, oe, ob;
    n = sel ? 16 : 8;
    build_model(n);
    vcyc.delete();
    ecyc.delete();
    for (int i = 0; i < stim.size(); i++) begin
      @(posedge clk);
      #1;
      if (sel != 0) rx2 = stim[i];
      else rx1 = stim[i];
      @(negedge clk);
      od = sel ? d2 : {8'h00, d1};
      ov = sel ? v2 : v1;
      oe = sel ? e2 : e1;
      ob = sel ? b2 : b1;
      if (ov === 1'b1) vcyc.push_back(i);
      if (oe === 1'b1) ecyc.push_back(i);
      check($sformatf("%s[%0d].valid", tag, i), {15'h0, ov}, {15'h0, exp_v[i]});
      check($sformatf("%s[%0d].err", tag, i), {15'h0, oe}, {15'h0, exp_e[i]});
      check($sformatf("%s[%0d].busy", tag, i), {15'h0, ob}, {15'h0, exp_b[i]});
      check($sformatf("%s[%0d].data", tag, i), od, exp_d[i]);
    end
    rx1 = 1'b1;
    rx2 = 1'b1;
  endtask

  int diff;

  initial begin
    // Reset held with rx toggling: everything stays cleared.
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      rx1 = 1'($urandom);
      rx2 = 1'($urandom);
      @(negedge clk);
      check($sformatf("hold_rst[%0d].u1", i), {5'h0, v1, e1, b1, d1}, 16'h0);
      check($sformatf("hold_rst[%0d].u2", i), {13'h0, v2, e2, b2}, 16'h0);
      check($sformatf("hold_rst[%0d].d2", i), d2, 16'h0);
    end
    do_reset("init");
    stim.delete();
    push_idle(10);
    run_seg(0, "idle10");
    check("idle10.nvalid", 16'(vcyc.size()), 16'd0);

    // Single frame 0xA5, start on rx in cycle 3: data_valid at cycle 15.
    do_reset("a5");
    stim.delete();
    push_idle(3);
    push_frame(8, 16'h00A5, 1'b1);
    push_idle(6);
    run_seg(0, "a5");
    check("a5.nvalid", 16'(vcyc.size()), 16'd1);
    if (vcyc.size() == 1) check("a5.vcycle", 16'(vcyc[0]), 16'd15);

    // Back-to-back 16-bit frames with a one-cycle stop.
    do_reset("b2b");
    stim.delete();
    push_idle(2);
    push_frame(16, 16'h1234, 1'b1);
    push_frame(16, 16'hFFFF, 1'b1);
    push_idle(8);
    run_seg(1, "b2b");
    check("b2b.nvalid", 16'(vcyc.size()), 16'd2);
    diff = (vcyc.size() == 2) ? vcyc[1] - vcyc[0] : -1;
    check("b2b.spacing", 16'(diff), 16'd18);

    // Good frame, framing error on 0x3C, then 0x81 recovers.
    do_reset("ferr");
    stim.delete();
    push_idle(2);
    push_frame(8, 16'h0066, 1'b1);
    push_idle(2);
    push_frame(8, 16'h003C, 1'b0);
    push_idle(5);
    push_frame(8, 16'h0081, 1'b1);
    push_idle(6);
    run_seg(0, "ferr");
    check("ferr.nerr", 16'(ecyc.size()), 16'd1);
    check("ferr.nvalid", 16'(vcyc.size()), 16'd2);
    check("ferr.final", {8'h00, d1}, 16'h0081);

    // Stuck-low line for 50 cycles: one error, no data.
    do_reset("stuck");
    stim.delete();
    for (int i = 0; i < 50; i++) stim.push_back(1'b0);
    push_idle(10);
    run_seg(0, "stuck");
    check("stuck.nerr", 16'(ecyc.size()), 16'd1);
    check("stuck.nvalid", 16'(vcyc.size()), 16'd0);

    // Reset after four data bits of 0x5A, then a clean 0x00 frame.
    do_reset("mid");
    stim.delete();
    push_idle(2);
    stim.push_back(1'b0);
    for (int k = 0; k < 4; k++) stim.push_back(((8'h5A >> k) & 8'h01) != 0);
    run_seg(0, "mid_a");
    do_reset("mid_rst");
    stim.delete();
    push_idle(4);
    push_frame(8, 16'h0000, 1'b1);
    push_idle(6);
    run_seg(0, "mid_b");
    check("mid.nvalid", 16'(vcyc.size()), 16'd1);

    // rx already low at reset release counts as a start bit.
    do_reset("lowrel");
    stim.delete();
    push_frame(8, 16'h00C3, 1'b1);
    push_idle(6);
    run_seg(0, "lowrel");

    // Randomised frame streams on both widths.
    for (int r = 0; r < 4; r++) begin
      do_reset($sformatf("rnd%0d", r));
      stim.delete();
      add_rand_frames((r % 2) ? 16 : 8, 6);
      run_seg(r % 2, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_lvds.md
Name: rx_lvds

Overview:
- Serial receiver for the single-wire LVDS link: deserialises frames produced by the link transmitter back into CH_NUM*8-bit parallel words.
- Frame format: idle line = 1; start bit = 0 (1 clk); CH_NUM*8 data bits, LSB first, 1 bit per clk; stop bit = 1 (>=1 clk).
- Sits at the receiving end of the link and feeds the downstream channel demux.
- Transmitter and receiver run on the same clock, so there is no oversampling: exactly one sample per bit.

Parameters:
- CH_NUM, default `CH_NUM (params.vh), number of 8-bit channels per frame. Data width N = CH_NUM*8. Legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line from the link transmitter.
- data_out  output  N  last correctly framed word; held stable between data_valid pulses.
- data_valid  output  1  one-clk pulse; data_out is new this cycle.
- frame_err  output  1  one-clk pulse; stop bit sampled 0 and the frame is discarded.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, bit counter=0, shift register=0, data_out=0, data_valid=0, frame_err=0, rx_busy=0, both sync flops=1 (line idle).
- Input path: 2-flop synchroniser rx -> s1 -> s2. The FSM uses s2 only.
- Bit counter: width clog2(N); it never counts past N-1.
- Shift register: right shift, s2 enters at bit N-1. After N shifts, the first received bit is at bit 0 (LSB first).
- State IDLE: if s2==0 the start bit is detected; go to DATA with cnt<=0. Otherwise stay in IDLE.
- State DATA: each clk, shift in s2 and increment cnt. When cnt==N-1 (the Nth data bit is shifted in this cycle), go to STOP.
- State STOP, s2==1: data_out<=shift register and data_valid<=1 (high the next cycle); go to IDLE.
- State STOP, s2==0: frame_err<=1; data_out unchanged; go to HUNT.
- State HUNT: wait for s2==1, then go to IDLE. This prevents a stuck-low line from being re-read as repeated start bits.
- Timing: if the start bit is on rx during cycle c, data bit k is on rx in cycle c+1+k and the stop bit in cycle c+1+N.
  - FSM samples start at the end of c+2, bit k at the end of c+3+k, stop at the end of c+3+N.
  - data_valid or frame_err is high in cycle c+4+N.
- Back-to-back frames (1-clk stop, next start immediately after) must be received with no loss. IDLE is entered exactly as the next start reaches s2.
- data_valid and frame_err are never high in the same cycle. Each is high for exactly 1 clk per frame.
- Data bits equal to 0 never restart the frame. Start is only detected in IDLE.
- rst_n low mid-frame: immediate return to reset values. The partial word is never emitted, and no pulse follows release.
- rx low at reset release is treated as a start bit once it reaches s2.

Test Plan:
- Reset: hold rst_n=0 with rx toggling -> all outputs 0, rx_busy=0. Release with rx=1 for 10 clk -> no pulses.
- Single frame, CH_NUM=1: send start, bits of 0xA5 LSB first, stop, with start on rx in cycle c -> data_valid=1 only in cycle c+12, data_out=0xA5, rx_busy high in cycles c+3..c+11.
- Back-to-back, CH_NUM=2: frames 0x1234 then 0xFFFF separated by a 1-clk stop -> two data_valid pulses exactly 18 clk apart, with data_out 0x1234 then 0xFFFF.
- Framing error, CH_NUM=1: frame 0x3C with stop=0, then line idle -> frame_err pulse at c+12, no data_valid, data_out keeps its previous value. A following good frame 0x81 is then received correctly.
- Stuck-low line: rx=0 for 50 clk then 1 -> exactly one frame_err, FSM stays in HUNT until rx_s=1, then returns to IDLE. No data_valid.
- Reset mid-frame: assert rst_n after 4 data bits of 0x5A, release, then send 0x00 -> no pulse for the aborted frame, one data_valid with data_out=0x00.
